cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 127 ++++++++++++
 tb/tb_cmp_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter in front of one shared unsigned magnitude comparator.
// Latency: grant 1 cycle after req is seen in IDLE, done/result 1 cycle later; one compare every 3 cycles.
// Backpressure: none on outputs; requesters hold req until done, and req is ignored while busy.
module cmp_arbiter #(
  parameter int SIZE = 4,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] a_in,
  input  logic [NREQ*SIZE-1:0] b_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic                 A_greater,
  output logic                 B_greater,
  output logic                 AB_equal,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  last_id;
  logic [IDW-1:0]  win_id;
  logic [SIZE-1:0] a_lat;
  logic [SIZE-1:0] b_lat;
  logic [IDW-1:0]  winner;

  // Per-requester operand views of the flat input buses.
  logic [SIZE-1:0] a_arr [NREQ];
  logic [SIZE-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = a_in[g*SIZE +: SIZE];
    assign b_arr[g] = b_in[g*SIZE +: SIZE];
  end

  // Search upward from the requester after the last one served, wrapping at NREQ.
  // The sum is kept one bit wider so the wrap is a single conditional subtract.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    logic [IDW:0]   cand;
    logic           found;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, last} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && r[cand[IDW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDW-1:0];
      end
    end
    return pick;
  endfunction

  // Round-robin winner among the currently asserted requests.
  always_comb begin
    winner = rr_pick(req, last_id);
  end

  assign busy = (state != IDLE);

  // Arbitrate in IDLE, compare in CMP, publish in RESP; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      A_greater <= 1'b0;
      B_greater <= 1'b0;
      AB_equal  <= 1'b0;
      last_id   <= IDW'(NREQ-1);
      win_id    <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (|req) begin
            gnt         <= '0;
            gnt[winner] <= 1'b1;
            win_id      <= winner;
            a_lat       <= a_arr[winner];
            b_lat       <= b_arr[winner];
            state       <= CMP;
          end else begin
            gnt <= '0;
          end
        end
        CMP: begin
          gnt       <= '0;
          A_greater <= (a_lat >  b_lat);
          B_greater <= (a_lat <  b_lat);
          AB_equal  <= (a_lat == b_lat);
          done      <= 1'b1;
          done_id   <= win_id;
          last_id   <= win_id;
          state     <= RESP;
        end
        RESP: begin
          gnt   <= '0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed and randomized bench for cmp_arbiter with a queue-based scoreboard.
// Latency: the reference model predicts grant and result cycles; the monitor checks every cycle.
// Backpressure: requesters hold req until their done pulse, then drop it.
module tb_cmp_arbiter;
  localparam int SIZE = 4;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);
  localparam int MAXV = (1 << SIZE) - 1;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req   = '0;
  logic [NREQ*SIZE-1:0] a_in  = '0;
  logic [NREQ*SIZE-1:0] b_in  = '0;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic                 A_greater;
  logic                 B_greater;
  logic                 AB_equal;
  logic                 busy;

  cmp_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .done_id(done_id),
    .A_greater(A_greater), .B_greater(B_greater), .AB_equal(AB_equal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int id;
    bit gt;
    bit lt;
    bit eq;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int   log_id[$];
  int   log_cyc[$];

  int cyc    = 0;
  int hold   = 0;
  int mlast  = NREQ - 1;
  int checks = 0;
  int errors = 0;

  exp_t m_e;
  int   m_w, m_a, m_b;

  int              e_id = 0;
  bit              e_gt = 1'b0, e_lt = 1'b0, e_eq = 1'b0;
  logic [NREQ-1:0] mon_g;
  bit              mon_d;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each compare occupies three cycles; the winner is the first
  // asserted requester after the last one served; the result is plain integer compare.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gq.delete();
      rq.delete();
      hold  = 0;
      mlast = NREQ - 1;
    end else begin
      cyc++;
      if (hold > 0) begin
        hold--;
      end else if (req != 0) begin
        m_w = -1;
        for (int off = 1; off <= NREQ && m_w < 0; off++) begin
          if (req[(mlast + off) % NREQ]) m_w = (mlast + off) % NREQ;
        end
        m_a = int'(a_in[m_w*SIZE +: SIZE]);
        m_b = int'(b_in[m_w*SIZE +: SIZE]);
        m_e.cyc = cyc;
        m_e.id  = m_w;
        m_e.gt  = (m_a > m_b);
        m_e.lt  = (m_a < m_b);
        m_e.eq  = (m_a == m_b);
        gq.push_back(m_e);
        m_e.cyc = cyc + 1;
        rq.push_back(m_e);
        mlast = m_w;
        hold  = 2;
      end
    end
  end

  // Monitor: compares every output on the falling edge against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      e_id = 0;
      e_gt = 1'b0;
      e_lt = 1'b0;
      e_eq = 1'b0;
    end else begin
      mon_g = '0;
      if (gq.size() > 0 && gq[0].cyc == cyc) mon_g = NREQ'(1 << gq[0].id);
      chk("gnt", int'(gnt), int'(mon_g));
      if (mon_g != 0) void'(gq.pop_front());
      mon_d = (rq.size() > 0 && rq[0].cyc == cyc);
      chk("done", int'(done), int'(mon_d));
      if (mon_d) begin
        e_id = rq[0].id;
        e_gt = rq[0].gt;
        e_lt = rq[0].lt;
        e_eq = rq[0].eq;
        void'(rq.pop_front());
      end
      chk("done_id", int'(done_id), e_id);
      chk("A_greater", int'(A_greater), int'(e_gt));
      chk("B_greater", int'(B_greater), int'(e_lt));
      chk("AB_equal", int'(AB_equal), int'(e_eq));
      chk("busy", int'(busy), int'(hold != 0));
      if (done) begin
        log_id.push_back(int'(done_id));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    a_in[i*SIZE +: SIZE] = a[SIZE-1:0];
    b_in[i*SIZE +: SIZE] = b[SIZE-1:0];
  endtask

  task automatic wait_gnt(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (gnt != 0) ok = 1'b1;
    end
    chk({name, " grant seen"}, int'(ok), 1);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    chk({name, " done seen"}, int'(ok), 1);
  endtask

  task automatic serve(input logic [NREQ-1:0] r, input string name);
    req = r;
    wait_done(name);
    req = '0;
    tick(2);
  endtask

  function automatic int pick_val();
    int m;
    m = int'($urandom_range(0, 3));
    if (m == 0) return 0;
    if (m == 1) return MAXV;
    return int'($urandom_range(0, MAXV));
  endfunction

  task automatic rnd_op(input int i);
    int a, b;
    a = pick_val();
    b = ($urandom_range(0, 3) == 0) ? a : pick_val();
    set_ops(i, a, b);
  endtask

  initial begin
    int base;
    int cyc0;

    // Reset values.
    tick(2);
    chk("rst gnt", int'(gnt), 0);
    chk("rst done", int'(done), 0);
    chk("rst done_id", int'(done_id), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst flags", int'({A_greater, B_greater, AB_equal}), 0);
    rst_n = 1'b1;

    // Single request from requester 2.
    set_ops(2, 9, 3);
    base = log_id.size();
    req  = 4'b0100;
    wait_gnt("single");
    chk("single gnt", int'(gnt), 4);
    wait_done("single");
    chk("single done_id", int'(done_id), 2);
    chk("single A_greater", int'(A_greater), 1);
    chk("single B_greater", int'(B_greater), 0);
    chk("single AB_equal", int'(AB_equal), 0);
    req = '0;
    tick(3);
    chk("single done count", log_id.size() - base, 1);

    // Equality and extremes.
    set_ops(0, MAXV, MAXV);
    serve(4'b0001, "equal");
    chk("equal AB_equal", int'(AB_equal), 1);
    chk("equal A_greater", int'(A_greater), 0);
    set_ops(0, 0, MAXV);
    serve(4'b0001, "extreme");
    chk("extreme B_greater", int'(B_greater), 1);
    chk("extreme AB_equal", int'(AB_equal), 0);

    // Operand change after grant must not affect the result.
    set_ops(1, 5, 7);
    req = 4'b0010;
    wait_gnt("latch");
    set_ops(1, 15, 7);
    wait_done("latch");
    chk("latch B_greater", int'(B_greater), 1);
    chk("latch done_id", int'(done_id), 1);
    req = '0;
    tick(2);

    // Rotation after requester 3 is served.
    serve(4'b1000, "rot3");
    chk("rot3 done_id", int'(done_id), 3);
    req = 4'b1001;
    wait_done("rot0");
    chk("rot0 done_id", int'(done_id), 0);
    req = '0;
    tick(2);

    // Full contention from reset.
    rst_n = 1'b0;
    tick(2);
    for (int i = 0; i < NREQ; i++) rnd_op(i);
    base  = log_id.size();
    cyc0  = cyc;
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 60 && (log_id.size() - base) < 12; i++) @(negedge clk);
    req = '0;
    tick(3);
    chk("contention count", log_id.size() - base, 12);
    if (log_id.size() - base >= 12) begin
      chk("contention first done cycle", log_cyc[base] - cyc0, 2);
      for (int i = 0; i < 12; i++) begin
        chk("contention done_id", log_id[base + i], i % NREQ);
        if (i > 0) chk("contention spacing", log_cyc[base + i] - log_cyc[base + i - 1], 3);
      end
    end

    // Reset during CMP aborts the compare.
    set_ops(2, 9, 3);
    req = 4'b0100;
    wait_gnt("abort");
    #2 rst_n = 1'b0;
    #1;
    chk("abort gnt", int'(gnt), 0);
    chk("abort done", int'(done), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done_id", int'(done_id), 0);
    chk("abort flags", int'({A_greater, B_greater, AB_equal}), 0);
    req = '0;
    tick(2);
    rst_n = 1'b1;
    base  = log_id.size();
    tick(12);
    chk("abort no done", log_id.size() - base, 0);

    // Randomized traffic with requesters holding req until served.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) req[done_id] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        rnd_op(i);
      end
    end
    req = '0;
    tick(8);
    chk("grant queue drained", gq.size(), 0);
    chk("result queue drained", rq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
